// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit serial link (transmit and receive ends).
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_bit_tx_if.sv
// Valid/ready payload handshake between a producer and the serial transmitter.
interface serial_bit_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/bit_period_timer.sv
// Loadable down-counter marking the last cycle of each serial bit period.
module bit_period_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic period_end
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Reloading at zero keeps consecutive periods seamless; restart aligns a new frame.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == '0)) begin
            cnt_d = Reload;
        end else begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign period_end = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_tx.sv
// UART-style frame transmitter: start, LSB-first data, optional even parity, stop.
module serial_bit_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    serial_bit_tx_if.slave   tx,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    import serial_link_pkg::*;

    localparam int unsigned IdxW = $clog2(DATA_BITS) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 period_end;

    assign accept = tx.tx_valid && ready_q;

    bit_period_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (accept),
        .period_end (period_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx.tx_data;
                    parity_d = ^tx.tx_data;
                    idx_d    = '0;
                end
            end
            START: begin
                if (period_end) state_d = DATA;
            end
            DATA: begin
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LastIdx) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            PARITY: begin
                if (period_end) state_d = STOP;
            end
            STOP: begin
                if (period_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        case (state_d)
            START:   tx_out_d = START_BIT;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            STOP:    tx_out_d = STOP_BIT;
            default: tx_out_d = LINE_IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_out_q <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_out_q <= tx_out_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx_out      = tx_out_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule
